session_ctrl: RTL and testbench

- Sequential stage directly downstream of the combinational authentication / feature-select decoder.
- Consumes the four one-hot role lines (ATadm, ATtest, ATuser, ATguest) and the seven feature lines (FT0..FT6).
- Opens a login session, checks the selected feature against per-role permission masks and grants exactly one feature at a time.
- Enforces an inactivity timeout and a lockout after repeated failed logins.

---
 rtl/session_ctrl.sv | 261 ++++++++++++++++++++++++++
 tb/tb_session_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/session_ctrl.sv
// -----------------------------------------------------------------------------
// session_ctrl
//   Login / feature-grant controller placed after the combinational
//   authentication and feature-select decoder. It opens a session for a
//   single decoded role, grants one permitted feature at a time, logs the
//   user out after an idle period, and locks the panel out after repeated
//   failed logins.
//
// Ports
//   clk                             system clock (rising edge)
//   rst                             synchronous, active-high reset
//   ATadm/ATtest/ATuser/ATguest     one-hot role lines from the decoder
//   FT0..FT6                        feature lines from the decoder
//   confirm                         debounced confirm button (acts on rising edge)
//   logout                          debounced logout button (level)
//   logged_in                       high in SESSION or ACTIVE
//   role[1:0]                       0 adm, 1 test, 2 user, 3 guest (0 when logged out)
//   feature_grant[6:0]              one-hot granted feature, zero unless ACTIVE
//   deny                            one-cycle pulse on a rejected request
//   locked                          high in LOCKOUT
//   state[1:0]                      0 IDLE, 1 SESSION, 2 ACTIVE, 3 LOCKOUT
//
// Optional build macro SESSION_CTRL_AUDIT_EN adds:
//   deny_count[7:0]                 saturating count of deny pulses (rst-only clear)
//   lockout_seen                    sticky flag set on the first LOCKOUT entry
// -----------------------------------------------------------------------------
module session_ctrl #(
  parameter int         TIMEOUT_CYCLES = 1000,
  parameter int         MAX_FAILS      = 3,
  parameter int         LOCK_CYCLES    = 500,
  parameter logic [6:0] ADM_MASK       = 7'h7F,
  parameter logic [6:0] TEST_MASK      = 7'h3F,
  parameter logic [6:0] USER_MASK      = 7'h0F,
  parameter logic [6:0] GUEST_MASK     = 7'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ATadm,
  input  logic       ATtest,
  input  logic       ATuser,
  input  logic       ATguest,
  input  logic       FT0,
  input  logic       FT1,
  input  logic       FT2,
  input  logic       FT3,
  input  logic       FT4,
  input  logic       FT5,
  input  logic       FT6,
  input  logic       confirm,
  input  logic       logout,
  output logic       logged_in,
  output logic [1:0] role,
  output logic [6:0] feature_grant,
  output logic       deny,
  output logic       locked,
  output logic [1:0] state
`ifdef SESSION_CTRL_AUDIT_EN
  ,
  output logic [7:0] deny_count,
  output logic       lockout_seen
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SESSION = 2'd1,
    S_ACTIVE  = 2'd2,
    S_LOCKOUT = 2'd3
  } state_t;

  localparam int TMR_W  = $clog2(TIMEOUT_CYCLES);
  localparam int LOCK_W = $clog2(LOCK_CYCLES);
  localparam int FAIL_W = (MAX_FAILS > 1) ? $clog2(MAX_FAILS) : 1;

  state_t              state_q, state_d;
  logic [1:0]          role_q, role_d;
  logic [6:0]          grant_q, grant_d;
  logic                deny_q, deny_d;
  logic                logged_in_q, logged_in_d;
  logic                locked_q, locked_d;
  logic                confirm_q, confirm_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [LOCK_W-1:0]   lock_q, lock_d;
  logic [FAIL_W-1:0]   fail_q, fail_d;

  logic [3:0] at_vec;
  logic [6:0] ft_vec;
  logic [1:0] at_role;
  logic [6:0] role_mask;
  logic       cfm_re;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic is_onehot7(input logic [6:0] v);
    return (v != 7'd0) && ((v & (v - 7'd1)) == 7'd0);
  endfunction

  assign at_vec = {ATguest, ATuser, ATtest, ATadm};
  assign ft_vec = {FT6, FT5, FT4, FT3, FT2, FT1, FT0};
  assign cfm_re = confirm & ~confirm_q;

  // Role index of the (assumed one-hot) role vector; only used when one-hot.
  always_comb begin
    at_role = 2'd0;
    case (at_vec)
      4'b0010: at_role = 2'd1;
      4'b0100: at_role = 2'd2;
      4'b1000: at_role = 2'd3;
      default: at_role = 2'd0;
    endcase
  end

  always_comb begin
    role_mask = ADM_MASK;
    case (role_q)
      2'd1:    role_mask = TEST_MASK;
      2'd2:    role_mask = USER_MASK;
      2'd3:    role_mask = GUEST_MASK;
      default: role_mask = ADM_MASK;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    role_d    = role_q;
    grant_d   = grant_q;
    deny_d    = 1'b0;
    fail_d    = fail_q;
    tmr_d     = tmr_q;
    lock_d    = lock_q;
    confirm_d = confirm;

    case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (cfm_re) begin
          if (is_onehot4(at_vec)) begin
            state_d = S_SESSION;
            role_d  = at_role;
            fail_d  = '0;
          end else if (fail_q == FAIL_W'(MAX_FAILS - 1)) begin
            // The attempt that exhausts the budget locks out rather than pulsing deny.
            state_d = S_LOCKOUT;
            fail_d  = '0;
            lock_d  = '0;
          end else begin
            deny_d = 1'b1;
            fail_d = fail_q + 1'b1;
          end
        end
      end

      S_SESSION: begin
        if (logout) begin
          state_d = S_IDLE;
          role_d  = 2'd0;
          tmr_d   = '0;
        end else if (cfm_re) begin
          tmr_d = '0;
          if (is_onehot7(ft_vec) && ((ft_vec & role_mask) != 7'd0)) begin
            state_d = S_ACTIVE;
            grant_d = ft_vec;
          end else begin
            deny_d = 1'b1;
          end
        end else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_IDLE;
          role_d  = 2'd0;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      S_ACTIVE: begin
        tmr_d = '0;
        if (logout) begin
          state_d = S_IDLE;
          role_d  = 2'd0;
          grant_d = 7'd0;
        end else if (cfm_re) begin
          state_d = S_SESSION;
          grant_d = 7'd0;
        end
      end

      default: begin
        if (lock_q == LOCK_W'(LOCK_CYCLES - 1)) begin
          state_d = S_IDLE;
          lock_d  = '0;
        end else begin
          lock_d = lock_q + 1'b1;
        end
      end
    endcase

    logged_in_d = (state_d == S_SESSION) || (state_d == S_ACTIVE);
    locked_d    = (state_d == S_LOCKOUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      role_q      <= 2'd0;
      grant_q     <= 7'd0;
      deny_q      <= 1'b0;
      logged_in_q <= 1'b0;
      locked_q    <= 1'b0;
      confirm_q   <= 1'b0;
      tmr_q       <= '0;
      lock_q      <= '0;
      fail_q      <= '0;
    end else begin
      state_q     <= state_d;
      role_q      <= role_d;
      grant_q     <= grant_d;
      deny_q      <= deny_d;
      logged_in_q <= logged_in_d;
      locked_q    <= locked_d;
      confirm_q   <= confirm_d;
      tmr_q       <= tmr_d;
      lock_q      <= lock_d;
      fail_q      <= fail_d;
    end
  end

  assign state         = state_q;
  assign role          = role_q;
  assign feature_grant = grant_q;
  assign deny          = deny_q;
  assign logged_in     = logged_in_q;
  assign locked        = locked_q;

`ifdef SESSION_CTRL_AUDIT_EN
  logic [7:0] deny_count_q, deny_count_d;
  logic       lockout_seen_q, lockout_seen_d;

  // Counts in step with the deny output so both appear on the same cycle.
  always_comb begin
    deny_count_d   = deny_count_q;
    lockout_seen_d = lockout_seen_q | (state_d == S_LOCKOUT);
    if (deny_d && (deny_count_q != 8'hFF)) deny_count_d = deny_count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      deny_count_q   <= 8'd0;
      lockout_seen_q <= 1'b0;
    end else begin
      deny_count_q   <= deny_count_d;
      lockout_seen_q <= lockout_seen_d;
    end
  end

  assign deny_count   = deny_count_q;
  assign lockout_seen = lockout_seen_q;
`endif

endmodule

// File: tb/tb_session_ctrl.sv
module tb_session_ctrl;
  localparam int T_CYC  = 10;
  localparam int M_FAIL = 3;
  localparam int L_CYC  = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ATadm = 0, ATtest = 0, ATuser = 0, ATguest = 0;
  logic FT0 = 0, FT1 = 0, FT2 = 0, FT3 = 0, FT4 = 0, FT5 = 0, FT6 = 0;
  logic confirm = 0, logout = 0;
  logic       logged_in, deny, locked;
  logic [1:0] role, state;
  logic [6:0] feature_grant;
`ifdef SESSION_CTRL_AUDIT_EN
  logic [7:0] deny_count;
  logic       lockout_seen;
`endif

  always #5 clk = ~clk;

  session_ctrl #(
    .TIMEOUT_CYCLES(T_CYC), .MAX_FAILS(M_FAIL), .LOCK_CYCLES(L_CYC),
    .ADM_MASK(7'h7F), .TEST_MASK(7'h3F), .USER_MASK(7'h0F), .GUEST_MASK(7'h01)
  ) dut (
    .clk(clk), .rst(rst),
    .ATadm(ATadm), .ATtest(ATtest), .ATuser(ATuser), .ATguest(ATguest),
    .FT0(FT0), .FT1(FT1), .FT2(FT2), .FT3(FT3), .FT4(FT4), .FT5(FT5), .FT6(FT6),
    .confirm(confirm), .logout(logout),
    .logged_in(logged_in), .role(role), .feature_grant(feature_grant),
    .deny(deny), .locked(locked), .state(state)
`ifdef SESSION_CTRL_AUDIT_EN
    , .deny_count(deny_count), .lockout_seen(lockout_seen)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Session described as "edges since last activity" and lockout as
  // "edges remaining", straight from the behavioural rules.
  int   m_mode;        // 0 idle, 1 session, 2 active, 3 lockout
  int   m_role;
  int   m_grant;
  int   m_deny;
  int   m_fails;
  int   m_idle;
  int   m_lock_left;
  bit   m_cfm_prev;
  int   m_deny_cnt;
  bit   m_lock_seen;
  bit   m_re;
  logic [3:0] m_at;
  logic [6:0] m_ft;

  function automatic int perm(input int r);
    case (r)
      0: return 'h7F;
      1: return 'h3F;
      2: return 'h0F;
      default: return 'h01;
    endcase
  endfunction

  function automatic int role_of(input logic [3:0] a);
    for (int i = 0; i < 4; i++) if (a[i]) return i;
    return 0;
  endfunction

  task automatic m_leave();
    m_mode = 0; m_role = 0; m_grant = 0;
  endtask

  always @(posedge clk) begin
    m_re = confirm && !m_cfm_prev;
    m_cfm_prev = confirm;
    m_at = {ATguest, ATuser, ATtest, ATadm};
    m_ft = {FT6, FT5, FT4, FT3, FT2, FT1, FT0};
    m_deny = 0;
    if (rst) begin
      m_mode = 0; m_role = 0; m_grant = 0; m_fails = 0; m_idle = 0;
      m_lock_left = 0; m_cfm_prev = 0; m_deny_cnt = 0; m_lock_seen = 0;
    end else begin
      case (m_mode)
        0: if (m_re) begin
          if ($countones(m_at) == 1) begin
            m_mode = 1; m_role = role_of(m_at); m_fails = 0; m_idle = 0;
          end else begin
            m_fails++;
            if (m_fails == M_FAIL) begin
              m_mode = 3; m_fails = 0; m_lock_left = L_CYC;
            end else m_deny = 1;
          end
        end
        1: if (logout) m_leave();
           else if (m_re) begin
             m_idle = 0;
             if ($countones(m_ft) == 1 && ((int'(m_ft) & perm(m_role)) != 0)) begin
               m_mode = 2; m_grant = int'(m_ft);
             end else m_deny = 1;
           end else begin
             m_idle++;
             if (m_idle == T_CYC) m_leave();
           end
        2: if (logout) m_leave();
           else if (m_re) begin m_mode = 1; m_grant = 0; m_idle = 0; end
        default: begin
          m_lock_left--;
          if (m_lock_left == 0) m_mode = 0;
        end
      endcase
      if (m_deny == 1 && m_deny_cnt < 255) m_deny_cnt++;
      if (m_mode == 3) m_lock_seen = 1;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("state", int'(state), m_mode);
      chk("logged_in", int'(logged_in), (m_mode == 1 || m_mode == 2) ? 1 : 0);
      chk("role", int'(role), m_role);
      chk("feature_grant", int'(feature_grant), m_grant);
      chk("deny", int'(deny), m_deny);
      chk("locked", int'(locked), (m_mode == 3) ? 1 : 0);
`ifdef SESSION_CTRL_AUDIT_EN
      chk("deny_count", int'(deny_count), m_deny_cnt);
      chk("lockout_seen", int'(lockout_seen), int'(m_lock_seen));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  // Raise confirm for one edge; outputs of that edge are visible on return.
  task automatic cfm_on();
    confirm = 1; @(posedge clk); #1; confirm = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, int'(state), 0);
    chk({tag, "_logged_in"}, int'(logged_in), 0);
    chk({tag, "_role"}, int'(role), 0);
    chk({tag, "_grant"}, int'(feature_grant), 0);
    chk({tag, "_deny"}, int'(deny), 0);
    chk({tag, "_locked"}, int'(locked), 0);
  endtask

  int cnt;

  initial begin
    rst = 1;
    @(posedge clk); #1;
    cmp_en = 1;
    tick(1);
    rst = 0;
    chk_reset_vals("rst");

    // User login
    ATuser = 1; cfm_on(); ATuser = 0;
    chk("login_state", int'(state), 1);
    chk("login_logged_in", int'(logged_in), 1);
    chk("login_role", int'(role), 2);
    chk("login_deny", int'(deny), 0);
    tick(1);

    // Non-permitted feature, then a permitted one
    FT5 = 1; cfm_on(); FT5 = 0;
    chk("ft5_deny", int'(deny), 1);
    chk("ft5_state", int'(state), 1);
    tick(1);
    chk("ft5_deny_gone", int'(deny), 0);
    FT2 = 1; cfm_on(); FT2 = 0;
    chk("ft2_grant", int'(feature_grant), 7'b0000100);
    chk("ft2_state", int'(state), 2);

    // Grant held while inputs change
    FT0 = 1; ATadm = 1; tick(3); FT0 = 0; ATadm = 0;
    chk("hold_grant", int'(feature_grant), 7'b0000100);

    // confirm and logout together in ACTIVE: logout wins
    confirm = 1; logout = 1; @(posedge clk); #1; confirm = 0; logout = 0;
    chk("lo_state", int'(state), 0);
    chk("lo_grant", int'(feature_grant), 0);
    chk("lo_role", int'(role), 0);
    tick(1);

    // logout in IDLE does nothing
    logout = 1; tick(2); logout = 0;

    // Three failed logins -> lockout
    cfm_on(); chk("fail1_deny", int'(deny), 1); chk("fail1_state", int'(state), 0); tick(1);
    ATadm = 1; ATtest = 1;
    cfm_on(); chk("fail2_deny", int'(deny), 1); tick(1);
    ATadm = 0; ATtest = 0;
    cfm_on();
    chk("fail3_state", int'(state), 3);
    chk("fail3_locked", int'(locked), 1);
    chk("fail3_deny", int'(deny), 0);
    // Inputs ignored in lockout
    ATadm = 1; cfm_on(); tick(1);
    logout = 1; tick(1); logout = 0;
    tick(L_CYC - 4);
    chk("lock_last_state", int'(state), 3);
    tick(1);
    ATadm = 0;
    chk("unlock_state", int'(state), 0);
    chk("unlock_locked", int'(locked), 0);
    tick(1);

    // One fail, then a good login clears the fail count
    ATadm = 1; ATuser = 1; cfm_on(); chk("multi_at_deny", int'(deny), 1); tick(1);
    ATuser = 0;
    // Admin session: confirm on cycle 5 restarts the idle count
    cfm_on(); ATadm = 0;
    chk("adm_state", int'(state), 1);
    chk("adm_role", int'(role), 0);
    tick(3);
    cfm_on();                       // rejected (no FT line), restarts timer
    chk("restart_deny", int'(deny), 1);
    tick(T_CYC - 1);
    chk("restart_still", int'(state), 1);
    tick(1);
    chk("restart_to_state", int'(state), 0);
    chk("restart_to_role", int'(role), 0);
    tick(1);

    // Plain timeout
    ATtest = 1; cfm_on(); ATtest = 0;
    chk("test_role", int'(role), 1);
    tick(T_CYC - 1);
    chk("to_before", int'(state), 1);
    tick(1);
    chk("to_state", int'(state), 0);
    chk("to_logged_in", int'(logged_in), 0);
    tick(1);

    // Two more fails do not lock because the count was cleared by the login
    cfm_on(); tick(1); cfm_on();
    chk("nolock_state", int'(state), 0);
    chk("nolock_deny", int'(deny), 1);
    tick(1);

    // Held confirm: one request only
    ATguest = 1; cfm_on(); ATguest = 0;
    chk("guest_role", int'(role), 3);
    tick(1);
    FT0 = 1; confirm = 1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (state == 2) cnt++;
    end
    confirm = 0; FT0 = 0;
    chk("held_cfm_active_cycles", cnt, 20);
    chk("held_grant", int'(feature_grant), 7'b0000001);

    // Reset mid-ACTIVE
    rst = 1; tick(1); rst = 0;
    chk_reset_vals("midrst");
    tick(1);

`ifdef SESSION_CTRL_AUDIT_EN
    ATadm = 1; cfm_on(); ATadm = 0; tick(1);
    for (int i = 0; i < 300; i++) begin
      cfm_on(); tick(1);
    end
    chk("audit_sat", int'(deny_count), 255);
    rst = 1; tick(1); rst = 0;
    chk("audit_clr", int'(deny_count), 0);
    chk("audit_seen_clr", int'(lockout_seen), 0);
    chk_reset_vals("audit_rst");
`endif

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
